// File: rtl/fetch_pc_sequencer.sv
// PC stage of the sail-core fetch path: owns the PC, issues one req/ack fetch at a
// time and presents the fetched word to decode until decode accepts it.
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] adder_in1,
  output logic [31:0] adder_in2,
  input  logic [31:0] adder_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        stall_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        misalign_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        squash_q, squash_d;
  logic        misalign_q, misalign_d;
  logic [31:0] target_aligned;

  assign target_aligned = {branch_target[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      redirect_pc_q <= 32'h0;
      inst_q        <= 32'h0;
      inst_pc_q     <= 32'h0;
      inst_valid_q  <= 1'b0;
      squash_q      <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      squash_q      <= squash_d;
      misalign_q    <= misalign_d;
    end
  end

  // Handshakes: imem_req is held with a stable imem_addr until a cycle with imem_ack,
  // which completes the transfer; inst_valid is held with stable inst_out/inst_pc
  // until a cycle with stall_in=0 (decode accepted) or branch_taken (flush).
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;
    squash_d      = squash_q;
    misalign_d    = branch_taken & (branch_target[1:0] != 2'b00);

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (branch_taken) begin
            pc_d     = target_aligned;
            squash_d = 1'b0;
          end else if (squash_q) begin
            pc_d     = redirect_pc_q;
            squash_d = 1'b0;
          end else begin
            inst_d       = imem_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = S_VALID;
          end
        end else if (branch_taken) begin
          // Address must stay stable under req; remember where to go once the ack lands.
          redirect_pc_d = target_aligned;
          squash_d      = 1'b1;
        end
      end
      S_VALID: begin
        if (branch_taken) begin
          pc_d         = target_aligned;
          inst_valid_d = 1'b0;
          state_d      = S_FETCH;
        end else if (!stall_in) begin
          pc_d         = adder_out;
          inst_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign adder_in1    = pc_q;
  assign adder_in2    = 32'd4;
  assign imem_req     = (state_q == S_FETCH);
  assign imem_addr    = pc_q;
  assign inst_valid   = inst_valid_q;
  assign inst_out     = inst_q;
  assign inst_pc      = inst_pc_q;
  assign misalign_err = misalign_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: random memory latency, stalls, branches and resets
// against a program-order model of which PC decode should see next.
module tb_fetch_pc_sequencer;

  localparam logic [31:0] KEY     = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // main instance
  logic        ack = 1'b0, stall = 1'b0, branch = 1'b0;
  logic [31:0] data = 32'h0, target = 32'h0;
  logic [31:0] a_in1, a_in2, a_out;
  logic        imem_req, inst_valid, misalign_err;
  logic [31:0] imem_addr, inst_out, inst_pc;
  logic [1:0]  dbg_state;

  assign a_out = a_in1 + a_in2;

  fetch_pc_sequencer #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst),
    .adder_in1(a_in1), .adder_in2(a_in2), .adder_out(a_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(ack), .imem_data(data),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .stall_in(stall), .branch_taken(branch), .branch_target(target),
    .misalign_err(misalign_err), .dbg_state(dbg_state)
  );

  // wrap-around instance: immediate ack, never stalled or redirected
  logic        w_ack = 1'b0;
  logic [31:0] w_data = 32'h0;
  logic [31:0] w_in1, w_in2, w_out;
  logic        w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_inst, w_pc;
  logic [1:0]  w_state;

  assign w_out = w_in1 + w_in2;

  fetch_pc_sequencer #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(rst),
    .adder_in1(w_in1), .adder_in2(w_in2), .adder_out(w_out),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_data(w_data),
    .inst_valid(w_valid), .inst_out(w_inst), .inst_pc(w_pc),
    .stall_in(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
    .misalign_err(w_mis), .dbg_state(w_state)
  );

  // scoreboard state
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc = 32'h0;
  logic        exp_mis = 1'b0;
  bit          phase0 = 1'b1;
  int          delivered = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: inputs still hold the values captured at the last posedge
  logic        prev_req = 1'b0, prev_valid = 1'b0, prev_rst = 1'b0, w_prev_req = 1'b0, w_prev_valid = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] w_exp = WRAP_PC;
  int          cyc = 0, last_rise = -1, idle_cyc = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (rst) begin
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_inst_out", inst_out, 32'h0);
      check("rst_misalign", 32'(misalign_err), 32'd0);
      last_rise = -1;
      idle_cyc  = 0;
      w_exp     = WRAP_PC;
    end else begin
      if (prev_rst) check("idle_then_req", 32'(imem_req), 32'd1);
      check("misalign", 32'(misalign_err), 32'(exp_mis));
      if (inst_valid) check("no_req_while_valid", 32'(imem_req), 32'd0);
      if (imem_req && prev_req && !ack) check("addr_stable", imem_addr, prev_addr);
      if (imem_req && (!prev_req || ack)) begin
        if (exp_q.size() == 0) check("fetch_addr_expected", 32'd0, 32'd1);
        else check("fetch_addr", imem_addr, exp_q[0]);
      end
      if (inst_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_inst", inst_pc, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e);
          check("inst_out", inst_out, e ^ KEY);
          cur_pc = e;
        end
        if (phase0 && last_rise >= 0) check("throughput", 32'(cyc - last_rise), 32'd3);
        last_rise = cyc;
        idle_cyc  = 0;
        delivered++;
      end else if (inst_valid && prev_valid) begin
        check("hold_pc", inst_pc, cur_pc);
        check("hold_out", inst_out, cur_pc ^ KEY);
      end
      idle_cyc++;
      if (idle_cyc == 100) check("progress_timeout", 32'(idle_cyc), 32'd0);
      if (w_req && !w_prev_req) check("wrap_fetch_addr", w_addr, w_exp);
      if (w_valid && !w_prev_valid) begin
        check("wrap_inst_pc", w_pc, w_exp);
        check("wrap_inst_out", w_inst, w_exp ^ KEY);
        w_exp = w_exp + 32'd4;
      end
    end
    prev_req     = imem_req;
    prev_valid   = inst_valid;
    prev_addr    = imem_addr;
    prev_rst     = rst;
    w_prev_req   = w_req;
    w_prev_valid = w_valid;
  end

  // driver + reference model: decide the inputs for the next posedge and record
  // which PC decode must see next (branch target wins, otherwise previous pc + 4)
  initial begin
    int wait_cnt;
    int rst_left;
    wait_cnt = 1;
    rst_left = 1;
    exp_q.delete();
    exp_q.push_back(32'h0);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      phase0 = (c < 25);
      w_ack  = w_req;
      w_data = w_addr ^ KEY;

      if (rst_left > 0) begin
        rst = 1'b1;
        rst_left--;
      end else if (!phase0 && $urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        rst_left = $urandom_range(0, 1);
      end else begin
        rst = 1'b0;
      end

      stall  = !phase0 && ($urandom_range(0, 2) == 0);
      branch = !phase0 && (rst || imem_req || inst_valid) && ($urandom_range(0, 9) == 0);
      target = 32'($urandom_range(0, 16'hFFFF));
      if ($urandom_range(0, 3) != 0) target[1:0] = 2'b00;

      if (imem_req) begin
        if (wait_cnt == 0) begin
          ack  = 1'b1;
          data = imem_addr ^ KEY;
          wait_cnt = phase0 ? 1 : $urandom_range(0, 3);
        end else begin
          ack = 1'b0;
          wait_cnt--;
        end
      end else begin
        ack  = !phase0 && ($urandom_range(0, 7) == 0);
        data = $urandom;
      end

      if (rst) begin
        exp_q.delete();
        exp_q.push_back(32'h0);
        exp_mis = 1'b0;
      end else begin
        exp_mis = branch && (target[1:0] != 2'b00);
        if (branch) begin
          exp_q.delete();
          exp_q.push_back({target[31:2], 2'b00});
        end else if (inst_valid && !stall) begin
          exp_q.push_back(cur_pc + 32'd4);
        end
      end
    end
    @(negedge clk);
    #1;
    check("enough_instructions", 32'(delivered > 100), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
